// File: rtl/calc_pkg.sv
// Shared definitions for the calc_engine arithmetic unit: opcode values,
// FSM state encoding and small helpers for overflow detection and the
// signed MIN/MAX limits used when saturating.
package calc_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDSUB,
    ST_MUL_ITER,
    ST_DIV_ITER,
    ST_FINISH
  } state_t;

  // Widest operand the MIN/MAX helpers can describe.
  localparam int MAX_W = 64;

  // Signed overflow of a +/- b: the effective operand signs agree
  // (b's sign flips for subtraction) and the result sign differs.
  function automatic logic add_ovf(input logic sa, input logic sb,
                                   input logic sub, input logic sr);
    logic sb_eff;
    sb_eff = sb ^ sub;
    return (sa == sb_eff) && (sr != sa);
  endfunction

  // Bit pattern of -2^(w-1) in the low w bits.
  function automatic logic [MAX_W-1:0] min_of(input int w);
    return {{(MAX_W-1){1'b0}}, 1'b1} << (w - 1);
  endfunction

  // Bit pattern of 2^(w-1)-1 in the low w bits.
  function automatic logic [MAX_W-1:0] max_of(input int w);
    return min_of(w) - {{(MAX_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/calc_addsub.sv
// N-bit adder/subtractor: sum = a + b when sub=0, a - b when sub=1
// (b inverted and sub used as carry-in). One instance is time-shared by
// the add/sub op, the Booth partial-product update and the divider's
// trial subtraction.
module calc_addsub
  import calc_pkg::*;
#(
  parameter int N = 12
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  output logic [N-1:0] sum
);

  assign sum = a + (b ^ {N{sub}}) + {{(N-1){1'b0}}, sub};

endmodule

// File: rtl/calc_engine.sv
// Sequential signed arithmetic engine: add, sub, radix-2 Booth multiply and
// signed restoring divide over a Start/Ready/Done handshake.
// Optional build macro CALC_SATURATE_EN: when defined, an overflowing result
// clamps to MAX/MIN of the true result's sign instead of wrapping.
module calc_engine
  import calc_pkg::*;
#(
  parameter int W  = 11,
  parameter int CW = $clog2(W + 1)
) (
  input  logic         Clock,
  input  logic         Reset_n,
  input  logic         Start,
  input  logic [1:0]   Op,
  input  logic [W-1:0] OperandA,
  input  logic [W-1:0] OperandB,
  output logic         Ready,
  output logic         Done,
  output logic [W-1:0] Result,
  output logic [W-1:0] Remainder,
  output logic         Overflow,
  output logic         DivByZero
);

  localparam logic [CW-1:0] CNT_INIT = CW'(W);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_t        state;
  logic [1:0]    op_r;
  logic [W:0]    acc;      // Booth P register, or divider partial remainder
  logic [W-1:0]  qreg;     // addend/multiplier, or dividend magnitude -> quotient
  logic [W-1:0]  mcand;    // multiplicand, or divisor magnitude
  logic [W-1:0]  opa;      // raw OperandA (augend / dividend for div-by-zero)
  logic          qm1;      // Booth q(-1) bit
  logic          a_neg;
  logic          b_neg;
  logic          dz_r;
  logic [CW-1:0] cnt;

  logic [W:0]    add_a;
  logic [W:0]    add_b;
  logic          add_sub;
  logic [W:0]    add_sum;

  logic [W-1:0]  a_mag;
  logic [W-1:0]  b_mag;
  logic [W:0]    mul_p;
  logic [W:0]    mul_hi;
  logic [W:0]    div_shift;

  logic [W-1:0]  raw_res;
  logic [W-1:0]  fin_res;
  logic [W-1:0]  fin_rem;
  logic          fin_ovf;
  logic          fin_dz;

  // Magnitudes of MIN come out as 2^(W-1), which is the right unsigned value.
  assign a_mag = OperandA[W-1] ? -OperandA : OperandA;
  assign b_mag = OperandB[W-1] ? -OperandB : OperandB;

  // Booth: keep P unchanged on 00/11, otherwise take the add/sub result.
  assign mul_p  = (qreg[0] ^ qm1) ? add_sum : acc;
  // Product bits [2W-1:W-1] must all match for the low W bits to be exact.
  assign mul_hi = {acc[W-1:0], qreg[W-1]};
  // Divider: shift the next dividend bit into the partial remainder.
  assign div_shift = {acc[W-1:0], qreg[W-1]};

  calc_addsub #(.N(W + 1)) u_addsub (
    .a   (add_a),
    .b   (add_b),
    .sub (add_sub),
    .sum (add_sum)
  );

  // Route the shared adder according to the active state.
  always_comb begin
    add_a   = acc;
    add_b   = {mcand[W-1], mcand};
    add_sub = 1'b0;
    case (state)
      ST_ADDSUB: begin
        add_a   = {opa[W-1], opa};
        add_b   = {qreg[W-1], qreg};
        add_sub = (op_r == OP_SUB);
      end
      ST_MUL_ITER: begin
        add_a   = acc;
        add_b   = {mcand[W-1], mcand};
        add_sub = qreg[0] & ~qm1;
      end
      ST_DIV_ITER: begin
        add_a   = div_shift;
        add_b   = {1'b0, mcand};
        add_sub = 1'b1;
      end
      default: ;
    endcase
  end

  // Final result, remainder and flags, including the divide sign fix-up.
  always_comb begin
    raw_res = acc[W-1:0];
    fin_rem = '0;
    fin_ovf = 1'b0;
    fin_dz  = 1'b0;
    case (op_r)
      OP_ADD, OP_SUB: begin
        fin_ovf = add_ovf(a_neg, b_neg, op_r == OP_SUB, acc[W-1]);
      end
      OP_MUL: begin
        raw_res = qreg;
        fin_ovf = ~((&mul_hi) | ~(|mul_hi));
      end
      default: begin
        if (dz_r) begin
          raw_res = '0;
          fin_rem = opa;
          fin_dz  = 1'b1;
        end else begin
          raw_res = (a_neg ^ b_neg) ? -qreg : qreg;
          fin_rem = a_neg ? -acc[W-1:0] : acc[W-1:0];
          // Only MIN / -1 yields a positive quotient magnitude of 2^(W-1).
          fin_ovf = ~(a_neg ^ b_neg) & qreg[W-1];
        end
      end
    endcase
  end

`ifdef CALC_SATURATE_EN
  localparam logic [MAX_W-1:0] MIN_WIDE = min_of(W);
  localparam logic [MAX_W-1:0] MAX_WIDE = max_of(W);
  localparam logic [W-1:0]     MIN_VAL  = MIN_WIDE[W-1:0];
  localparam logic [W-1:0]     MAX_VAL  = MAX_WIDE[W-1:0];

  logic fin_neg;
  // Sign of the exact result: the extra adder/P bit, or the quotient sign.
  assign fin_neg = (op_r == OP_DIV) ? (a_neg ^ b_neg) : acc[W];
  assign fin_res = fin_ovf ? (fin_neg ? MIN_VAL : MAX_VAL) : raw_res;
`else
  assign fin_res = raw_res;
`endif

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= ST_IDLE;
      op_r      <= OP_ADD;
      acc       <= '0;
      qreg      <= '0;
      mcand     <= '0;
      opa       <= '0;
      qm1       <= 1'b0;
      a_neg     <= 1'b0;
      b_neg     <= 1'b0;
      dz_r      <= 1'b0;
      cnt       <= '0;
      Ready     <= 1'b1;
      Done      <= 1'b0;
      Result    <= '0;
      Remainder <= '0;
      Overflow  <= 1'b0;
      DivByZero <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        ST_IDLE: begin
          // Ready is held low through the Done cycle so a Start there is dropped.
          if (Done) Ready <= 1'b1;
          if (Start && Ready) begin
            Ready <= 1'b0;
            op_r  <= Op;
            opa   <= OperandA;
            a_neg <= OperandA[W-1];
            b_neg <= OperandB[W-1];
            dz_r  <= 1'b0;
            cnt   <= '0;
            case (Op)
              OP_ADD, OP_SUB: begin
                qreg  <= OperandB;
                state <= ST_ADDSUB;
              end
              OP_MUL: begin
                acc   <= '0;
                qreg  <= OperandB;
                qm1   <= 1'b0;
                mcand <= OperandA;
                cnt   <= CNT_INIT;
                state <= ST_MUL_ITER;
              end
              default: begin
                if (OperandB == '0) begin
                  // One wait cycle in FINISH matches the add/sub latency.
                  dz_r  <= 1'b1;
                  cnt   <= CNT_ONE;
                  state <= ST_FINISH;
                end else begin
                  acc   <= '0;
                  qreg  <= a_mag;
                  mcand <= b_mag;
                  cnt   <= CNT_INIT;
                  state <= ST_DIV_ITER;
                end
              end
            endcase
          end
        end
        ST_ADDSUB: begin
          acc   <= add_sum;
          state <= ST_FINISH;
        end
        ST_MUL_ITER: begin
          if (cnt == '0) begin
            state <= ST_FINISH;
          end else begin
            acc  <= {mul_p[W], mul_p[W:1]};
            qreg <= {mul_p[0], qreg[W-1:1]};
            qm1  <= qreg[0];
            cnt  <= cnt - CNT_ONE;
          end
        end
        ST_DIV_ITER: begin
          if (cnt == '0) begin
            state <= ST_FINISH;
          end else begin
            if (!add_sum[W]) begin
              acc  <= add_sum;
              qreg <= {qreg[W-2:0], 1'b1};
            end else begin
              acc  <= div_shift;
              qreg <= {qreg[W-2:0], 1'b0};
            end
            cnt <= cnt - CNT_ONE;
          end
        end
        ST_FINISH: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_ONE;
          end else begin
            Result    <= fin_res;
            Remainder <= fin_rem;
            Overflow  <= fin_ovf;
            DivByZero <= fin_dz;
            Done      <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_engine.sv
// Directed testbench for calc_engine (W=11): add/sub/mul/div results, flags,
// latency, ignored Start requests and reset during an operation.
module tb_calc_engine;
  import calc_pkg::*;

  localparam int W = 11;

`ifdef CALC_SATURATE_EN
  localparam int ADD_OVF_RES = 1023;
  localparam int SUB_OVF_RES = -1024;
  localparam int MUL_OVF_RES = 1023;
  localparam int DIV_OVF_RES = 1023;
`else
  localparam int ADD_OVF_RES = -948;
  localparam int SUB_OVF_RES = 1023;
  localparam int MUL_OVF_RES = -48;
  localparam int DIV_OVF_RES = -1024;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         ready;
  logic         done;
  logic [W-1:0] result;
  logic [W-1:0] remainder;
  logic         overflow;
  logic         div_by_zero;

  int checks = 0;
  int failures = 0;
  int lat;
  int seen;

  calc_engine #(.W(W)) dut (
    .Clock     (clk),
    .Reset_n   (rst_n),
    .Start     (start),
    .Op        (op),
    .OperandA  (a),
    .OperandB  (b),
    .Ready     (ready),
    .Done      (done),
    .Result    (result),
    .Remainder (remainder),
    .Overflow  (overflow),
    .DivByZero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Count edges after the accept edge until Done is seen (bounded).
  task automatic wait_done(input int from, output int n);
    n = from;
    while (done !== 1'b1 && n < 80) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  // Issue one op, wait for Done, then probe that a Start on the Done
  // cycle is ignored and Ready returns in the following cycle.
  task automatic do_op(input logic [1:0] o, input int av, input int bv, output int n);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    a     = av[W-1:0];
    b     = bv[W-1:0];
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(0, n);
    check("ready_low_on_done", int'(ready), 0);
    start = 1'b1;
    op    = OP_ADD;
    a     = 11'd1;
    b     = 11'd1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("ready_after_done", int'(ready), 1);
    check("done_one_cycle", int'(done), 0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", int'(ready), 1);
    check("rst_done", int'(done), 0);
    check("rst_result", int'(result), 0);
    check("rst_rem", int'(remainder), 0);
    check("rst_ovf", int'(overflow), 0);
    check("rst_dz", int'(div_by_zero), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1000 + 100 overflows
    do_op(OP_ADD, 1000, 100, lat);
    check("add_lat", lat, 2);
    check("add_res", $signed(result), ADD_OVF_RES);
    check("add_ovf", int'(overflow), 1);
    check("add_rem", int'(remainder), 0);

    // -1024 - 1 overflows
    do_op(OP_SUB, -1024, 1, lat);
    check("sub_ovf_res", $signed(result), SUB_OVF_RES);
    check("sub_ovf", int'(overflow), 1);

    // 5 - 9
    do_op(OP_SUB, 5, 9, lat);
    check("sub_lat", lat, 2);
    check("sub_res", $signed(result), -4);
    check("sub_ovf_clr", int'(overflow), 0);

    // -7 * 6
    do_op(OP_MUL, -7, 6, lat);
    check("mul_lat", lat, W + 2);
    check("mul_res", $signed(result), -42);
    check("mul_ovf", int'(overflow), 0);

    // 100 * 20 = 2000 overflows
    do_op(OP_MUL, 100, 20, lat);
    check("mul_ovf_res", $signed(result), MUL_OVF_RES);
    check("mul_ovf_flag", int'(overflow), 1);

    // -100 / 7
    do_op(OP_DIV, -100, 7, lat);
    check("div_lat", lat, W + 2);
    check("div1_q", $signed(result), -14);
    check("div1_r", $signed(remainder), -2);
    check("div1_ovf", int'(overflow), 0);

    // 100 / -7
    do_op(OP_DIV, 100, -7, lat);
    check("div2_q", $signed(result), -14);
    check("div2_r", $signed(remainder), 2);

    // -1024 / -1 overflows
    do_op(OP_DIV, -1024, -1, lat);
    check("div_min_q", $signed(result), DIV_OVF_RES);
    check("div_min_r", $signed(remainder), 0);
    check("div_min_ovf", int'(overflow), 1);

    // 55 / 0
    do_op(OP_DIV, 55, 0, lat);
    check("dz_lat", lat, 2);
    check("dz_res", $signed(result), 0);
    check("dz_rem", $signed(remainder), 55);
    check("dz_flag", int'(div_by_zero), 1);
    check("dz_ovf", int'(overflow), 0);

    // 3 * -5 with Start held high and different operands mid-operation
    @(negedge clk);
    start = 1'b1;
    op    = OP_MUL;
    a     = 11'd3;
    b     = 11'h7FB;
    @(posedge clk);
    #1;
    op = OP_ADD;
    a  = 11'd7;
    b  = 11'd7;
    repeat (5) @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(5, lat);
    check("held_lat", lat, W + 2);
    check("held_res", $signed(result), -15);
    check("held_dz_clr", int'(div_by_zero), 0);
    @(posedge clk);
    #1;
    check("held_ready", int'(ready), 1);

    // Reset pulsed in the middle of a divide
    @(negedge clk);
    start = 1'b1;
    op    = OP_DIV;
    a     = 11'd100;
    b     = 11'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", int'(ready), 1);
    check("mid_rst_done", int'(done), 0);
    check("mid_rst_result", int'(result), 0);
    check("mid_rst_rem", int'(remainder), 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) seen = 1;
    end
    check("mid_rst_no_done", seen, 0);

    do_op(OP_DIV, 100, 7, lat);
    check("post_rst_lat", lat, W + 2);
    check("post_rst_q", $signed(result), 14);
    check("post_rst_r", $signed(remainder), 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
